// File: rtl/alu_arb.sv
// alu_arb: two-requester front end for a shared combinational ALU; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_arb #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [31:0] req0_srca,
  input  logic [31:0] req0_srcb,
  input  logic [3:0]  req0_cntl,
  input  logic        req0_not_s,
  input  logic        req1_vld,
  output logic        req1_rdy,
  input  logic [31:0] req1_srca,
  input  logic [31:0] req1_srcb,
  input  logic [3:0]  req1_cntl,
  input  logic        req1_not_s,
  output logic        resp0_vld,
  input  logic        resp0_rdy,
  output logic        resp1_vld,
  input  logic        resp1_rdy,
  output logic [31:0] resp_result,
  output logic [1:0]  resp_cnd,
  output logic [31:0] alu_srca,
  output logic [31:0] alu_srcb,
  output logic [3:0]  alu_cntl,
  output logic        alu_not_s,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_cnd
);
  logic        s1_vld_q, s1_vld_d, s1_own_q, s1_own_d, s1_not_s_q, s1_not_s_d;
  logic [31:0] s1_srca_q, s1_srca_d, s1_srcb_q, s1_srcb_d;
  logic [3:0]  s1_cntl_q, s1_cntl_d;
  logic        s2_vld_q, s2_vld_d, s2_own_q, s2_own_d;
  logic [31:0] s2_res_q, s2_res_d;
  logic [1:0]  s2_cnd_q, s2_cnd_d;
  logic        rr_q, rr_d;
  logic        s2_adv, s1_adv, can_gnt, pick1, gnt0, gnt1;
  // pipeline advance, arbitration and grant; rr_q holds the requester favoured on the next contention
  always_comb begin
    s2_adv  = s2_vld_q & (s2_own_q ? resp1_rdy : resp0_rdy);
    s1_adv  = s1_vld_q & (~s2_vld_q | s2_adv);
    can_gnt = ~rst & (~s1_vld_q | s1_adv);
`ifdef ALU_ARB_RR_EN
    pick1   = req1_vld & (~req0_vld | rr_q);
`else
    pick1   = req1_vld & ~req0_vld;
`endif
    gnt1    = can_gnt & pick1;
    gnt0    = can_gnt & req0_vld & ~pick1;
    rr_d    = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_q;
  end
  // next state of both stages: S1 takes only the winner's operands, S2 captures the ALU on S1 advance
  always_comb begin
    s1_vld_d   = gnt0 | gnt1 | (s1_vld_q & ~s1_adv);
    s1_own_d   = gnt1 ? 1'b1 : gnt0 ? 1'b0 : s1_own_q;
    s1_srca_d  = gnt1 ? req1_srca : gnt0 ? req0_srca : s1_srca_q;
    s1_srcb_d  = gnt1 ? req1_srcb : gnt0 ? req0_srcb : s1_srcb_q;
    s1_cntl_d  = gnt1 ? req1_cntl : gnt0 ? req0_cntl : s1_cntl_q;
    s1_not_s_d = gnt1 ? req1_not_s : gnt0 ? req0_not_s : s1_not_s_q;
    s2_vld_d   = s1_adv | (s2_vld_q & ~s2_adv);
    s2_own_d   = s1_adv ? s1_own_q : s2_own_q;
    s2_res_d   = s1_adv ? alu_result : s2_res_q;
    s2_cnd_d   = s1_adv ? alu_cnd : s2_cnd_q;
  end
  // state registers; reset drops in-flight work and rewinds the arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_own_q   <= 1'b0;
      s1_srca_q  <= '0;
      s1_srcb_q  <= '0;
      s1_cntl_q  <= '0;
      s1_not_s_q <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_own_q   <= 1'b0;
      s2_res_q   <= '0;
      s2_cnd_q   <= '0;
      rr_q       <= RR_INIT;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_own_q   <= s1_own_d;
      s1_srca_q  <= s1_srca_d;
      s1_srcb_q  <= s1_srcb_d;
      s1_cntl_q  <= s1_cntl_d;
      s1_not_s_q <= s1_not_s_d;
      s2_vld_q   <= s2_vld_d;
      s2_own_q   <= s2_own_d;
      s2_res_q   <= s2_res_d;
      s2_cnd_q   <= s2_cnd_d;
      rr_q       <= rr_d;
    end
  end
  assign req0_rdy    = gnt0;
  assign req1_rdy    = gnt1;
  assign resp0_vld   = ~rst & s2_vld_q & ~s2_own_q;
  assign resp1_vld   = ~rst & s2_vld_q & s2_own_q;
  assign resp_result = s2_res_q;
  assign resp_cnd    = s2_cnd_q;
  assign alu_srca    = s1_srca_q;
  assign alu_srcb    = s1_srcb_q;
  assign alu_cntl    = s1_cntl_q;
  assign alu_not_s   = s1_not_s_q;
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the requester index (0/1) favoured on the first contention after reset.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have: reqN_vld  in  1  requester N operation valid (N=0,1).
REQ-005 SHALL have: reqN_rdy  out  1  requester N operation accepted this cycle.
REQ-006 SHALL have: reqN_srca, reqN_srcb  in  32  operands.
REQ-007 SHALL have: reqN_cntl  in  4  ALU opcode, same encoding as the ALU (ADD=0 ... AM=10).
REQ-008 SHALL have: reqN_not_s  in  1  sign-significant flag passed to the ALU.
REQ-009 SHALL have: respN_vld  out  1  result for requester N valid.
REQ-010 SHALL have: respN_rdy  in  1  requester N accepts result.
REQ-011 SHALL have: resp_result  out  32 and resp_cnd  out  2, shared by both response channels.
REQ-012 SHALL have: alu_srca, alu_srcb  out  32; alu_cntl  out  4; alu_not_s  out  1, driving the shared ALU.
REQ-013 SHALL have: alu_result  in  32 and alu_cnd  in  2, from the shared ALU.

Function
REQ-014 SHALL be a two-stage pipeline: S1 (operand register plus owner bit) and S2 (result register plus owner bit), each with a valid flag.
REQ-015 SHALL drive the alu_* outputs directly from the S1 register; the ALU is combinational in the S1 cycle.
REQ-016 SHALL complete a handshake when reqN_vld and reqN_rdy are both 1; at most one reqN_rdy is 1 per cycle.
REQ-017 SHALL define S2 advancing as S2 valid and the owner's respN_rdy=1.
REQ-018 SHALL define S1 advancing as S1 valid and (S2 empty or S2 advancing).
REQ-019 SHALL allow a grant only when S1 is empty or S1 is advancing; reqN_rdy SHALL be combinational from the req*_vld inputs and the pipeline state.
REQ-020 SHALL load S1 with the operands and owner of an accepted request on the clock edge ending the handshake cycle.
REQ-021 SHALL load S2 from alu_result/alu_cnd and the S1 owner on the edge where S1 advances.
REQ-022 SHALL assert respN_vld only when S2 is valid and owned by N; resp_result/resp_cnd SHALL show S2 contents.
REQ-023 SHALL give a latency of 2 cycles from accept to respN_vld when there is no stall, and a throughput of one operation per cycle.
REQ-024 SHALL hold S2, respN_vld and resp_result stable while respN_rdy=0; S1 SHALL then hold, and grants SHALL stop when S1 is full.
REQ-025 SHALL grant the only requester when exactly one reqN_vld=1.
REQ-026 SHALL resolve simultaneous requests with the arbitration policy (REQ-031/032); the loser's operands SHALL NOT be sampled, and it waits with vld held.
REQ-027 SHALL accept a new request in the same cycle S2 drains and S1 advances (full-pipeline pass-through).
REQ-028 SHALL ignore respN_rdy when respN_vld=0.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear both valid flags and set the RR pointer so RR_INIT is favoured; it SHALL discard any in-flight operation without producing a response.
REQ-030 SHALL hold reqN_rdy=0 and respN_vld=0 while rst=1; the data registers SHALL reset to 0, so alu_*=0, resp_result=0 and resp_cnd=0.

Configuration
REQ-031 SHALL, with macro ALU_ARB_RR_EN defined, use round-robin arbitration: on contention grant the requester not granted last; the pointer SHALL update only on an actual grant.
REQ-032 SHALL, without ALU_ARB_RR_EN, use fixed priority: requester 0 always wins contention; RR_INIT and the pointer have no effect.

Verification
REQ-033 SHALL cover single op: req0 ADD srca=5 srcb=7 accepted at cycle 0 -> resp0_vld at cycle 2, resp_result=12, resp_cnd=2'b10.
REQ-034 SHALL cover contention under ALU_ARB_RR_EN with RR_INIT=0: both requesters held valid for 4 cycles -> grants 0,1,0,1; without the macro -> grants 0,0,0,0 and req1_rdy stays 0.
REQ-035 SHALL cover backpressure: resp1_rdy=0 for 3 cycles with req1 SUB 3-3 in S2 -> resp1_vld and result 0 held stable, cnd=2'b11; req0_rdy=0 once S1 is full; the pipeline resumes when resp1_rdy=1.
REQ-036 SHALL cover back-to-back ops: req0 XOR, SLL, AND on consecutive cycles with all respN_rdy=1 -> three results on consecutive cycles, in order, with correct owner.
REQ-037 SHALL cover reset mid-operation: rst pulsed while S1 and S2 are valid -> no respN_vld afterwards, rdy=0 during rst, and the first contention after reset is granted to RR_INIT.
